// File: rtl/ball_mover.sv
// Ball position/motion controller for a frame-rate playfield.
// Three-state FSM (PARKED / MOVING / PAUSED) driven by HID keycodes.
// Wall limits are applied per axis with bounce or clamp behaviour.
// A launch edge out of PARKED or PAUSED also takes the first motion step
// on that same edge.
module ball_mover #(
  parameter int W         = 10,
  parameter int X_CENTER  = 320,
  parameter int Y_CENTER  = 240,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int SIZE      = 4,
  parameter int STEP      = 1,
  parameter int WALL_MODE = 0
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic [7:0]   keycode,
  output logic [W-1:0] BallX,
  output logic [W-1:0] BallY,
  output logic [W-1:0] BallS,
  output logic         moving,
  output logic         bounce
);

  localparam logic [7:0] K_LAUNCH = 8'h2C;
  localparam logic [7:0] K_PARK   = 8'h29;
  localparam logic [7:0] K_LEFT   = 8'h04;
  localparam logic [7:0] K_RIGHT  = 8'h07;
  localparam logic [7:0] K_DOWN   = 8'h16;
  localparam logic [7:0] K_UP     = 8'h1A;

  localparam logic signed [W-1:0] M_POS  = W'(STEP);
  localparam logic signed [W-1:0] M_NEG  = -M_POS;
  localparam logic signed [W-1:0] M_ZERO = '0;

  localparam logic [W-1:0] P_XC = W'(X_CENTER);
  localparam logic [W-1:0] P_YC = W'(Y_CENTER);

  localparam logic signed [W:0] L_XMIN = (W+1)'(X_MIN);
  localparam logic signed [W:0] L_XMAX = (W+1)'(X_MAX);
  localparam logic signed [W:0] L_YMIN = (W+1)'(Y_MIN);
  localparam logic signed [W:0] L_YMAX = (W+1)'(Y_MAX);
  localparam logic signed [W:0] L_SIZE = (W+1)'(SIZE);

  typedef enum logic [1:0] {S_PARKED, S_MOVING, S_PAUSED} state_t;

  typedef struct packed {
    logic [W-1:0] pos;
    logic [W-1:0] mot;
    logic         hit;
  } axis_t;

  // One axis step: candidate = pos + motion in W+1 signed bits, then wall limit.
  function automatic axis_t limit_axis(input logic [W-1:0]        pos,
                                       input logic signed [W-1:0] mot,
                                       input logic signed [W:0]   lo,
                                       input logic signed [W:0]   hi);
    logic signed [W:0] cand;
    logic signed [W:0] lim_pos;
    axis_t             res;
    cand    = $signed({1'b0, pos}) + $signed({mot[W-1], mot});
    lim_pos = cand;
    res.pos = cand[W-1:0];
    res.mot = mot;
    res.hit = 1'b0;
    if (cand + L_SIZE > hi) begin
      lim_pos = hi - L_SIZE;
      res.pos = lim_pos[W-1:0];
      res.mot = (WALL_MODE != 0) ? M_ZERO : M_NEG;
      res.hit = 1'b1;
    end else if (cand - L_SIZE < lo) begin
      lim_pos = lo + L_SIZE;
      res.pos = lim_pos[W-1:0];
      res.mot = (WALL_MODE != 0) ? M_ZERO : M_POS;
      res.hit = 1'b1;
    end
    return res;
  endfunction

  state_t              r_state;
  logic [W-1:0]        r_x;
  logic [W-1:0]        r_y;
  logic signed [W-1:0] r_mx;
  logic signed [W-1:0] r_my;
  logic [7:0]          r_prev_key;
  logic                r_moving;
  logic                r_bounce;

  logic                w_launch;
  logic signed [W-1:0] w_mx_next;
  logic signed [W-1:0] w_my_next;
  axis_t               w_ax;
  axis_t               w_ay;

  assign w_launch = (keycode == K_LAUNCH) && (r_prev_key != K_LAUNCH);

  // Motion for this step: launch default out of PARKED, stored otherwise, key override on top.
  always_comb begin
    w_mx_next = (r_state == S_PARKED) ? M_POS : r_mx;
    w_my_next = (r_state == S_PARKED) ? M_NEG : r_my;
    case (keycode)
      K_LEFT:  begin w_mx_next = M_NEG;  w_my_next = M_ZERO; end
      K_RIGHT: begin w_mx_next = M_POS;  w_my_next = M_ZERO; end
      K_DOWN:  begin w_mx_next = M_ZERO; w_my_next = M_POS;  end
      K_UP:    begin w_mx_next = M_ZERO; w_my_next = M_NEG;  end
      default: ;
    endcase
  end

  assign w_ax = limit_axis(r_x, w_mx_next, L_XMIN, L_XMAX);
  assign w_ay = limit_axis(r_y, w_my_next, L_YMIN, L_YMAX);

  // FSM, position/motion registers and registered status outputs.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state    <= S_PARKED;
      r_x        <= P_XC;
      r_y        <= P_YC;
      r_mx       <= M_ZERO;
      r_my       <= M_ZERO;
      r_prev_key <= 8'h00;
      r_moving   <= 1'b0;
      r_bounce   <= 1'b0;
    end else begin
      r_prev_key <= keycode;
      r_bounce   <= 1'b0;
      case (r_state)
        S_PARKED: begin
          r_x  <= P_XC;
          r_y  <= P_YC;
          r_mx <= M_ZERO;
          r_my <= M_ZERO;
          if (w_launch) begin
            r_state  <= S_MOVING;
            r_moving <= 1'b1;
            r_x      <= w_ax.pos;
            r_y      <= w_ay.pos;
            r_mx     <= w_ax.mot;
            r_my     <= w_ay.mot;
            r_bounce <= w_ax.hit | w_ay.hit;
          end
        end
        S_MOVING: begin
          if (w_launch) begin
            r_state  <= S_PAUSED;
            r_moving <= 1'b0;
          end else if (keycode == K_PARK) begin
            r_state  <= S_PARKED;
            r_moving <= 1'b0;
            r_x      <= P_XC;
            r_y      <= P_YC;
            r_mx     <= M_ZERO;
            r_my     <= M_ZERO;
          end else begin
            r_x      <= w_ax.pos;
            r_y      <= w_ay.pos;
            r_mx     <= w_ax.mot;
            r_my     <= w_ay.mot;
            r_bounce <= w_ax.hit | w_ay.hit;
          end
        end
        S_PAUSED: begin
          if (w_launch) begin
            r_state  <= S_MOVING;
            r_moving <= 1'b1;
            r_x      <= w_ax.pos;
            r_y      <= w_ay.pos;
            r_mx     <= w_ax.mot;
            r_my     <= w_ay.mot;
            r_bounce <= w_ax.hit | w_ay.hit;
          end else if (keycode == K_PARK) begin
            r_state  <= S_PARKED;
            r_x      <= P_XC;
            r_y      <= P_YC;
            r_mx     <= M_ZERO;
            r_my     <= M_ZERO;
          end
        end
        default: begin
          r_state  <= S_PARKED;
          r_moving <= 1'b0;
        end
      endcase
    end
  end

  assign BallX  = r_x;
  assign BallY  = r_y;
  assign BallS  = W'(SIZE);
  assign moving = r_moving;
  assign bounce = r_bounce;

endmodule

// File: doc/ball_mover.md
BALL_MOVER -- requirements
Module: ball_mover

Interface
REQ-001 Parameter W, default 10: coordinate and motion width in bits.
REQ-002 Parameter X_CENTER, default 320: park X coordinate.
REQ-003 Parameter Y_CENTER, default 240: park Y coordinate.
REQ-004 Parameter X_MIN, default 0; X_MAX, default 639: horizontal playfield bounds, inclusive.
REQ-005 Parameter Y_MIN, default 0; Y_MAX, default 479: vertical playfield bounds, inclusive.
REQ-006 Parameter SIZE, default 4: half-extent of the ball in pixels; constant.
REQ-007 Parameter STEP, default 1: magnitude of per-frame motion; 1 <= STEP <= SIZE.
REQ-008 Parameter WALL_MODE, default 0: 0 = bounce at walls, 1 = clamp and stop at walls.
REQ-009 Clock and reset: one clock, frame_clk; Reset is synchronous and active-high.
REQ-010 frame_clk  input  1  frame-rate clock; all state updates on its rising edge.
REQ-011 Reset  input  1  synchronous, active-high reset.
REQ-012 keycode  input  8  USB HID keycode of the currently held key; 0 = none.
REQ-013 BallX  output  W  ball centre X.
REQ-014 BallY  output  W  ball centre Y.
REQ-015 BallS  output  W  constant SIZE.
REQ-016 moving  output  1  high while the FSM is in MOVING.
REQ-017 bounce  output  1  one-cycle pulse on any cycle in which a wall limit is applied.

Function
REQ-018 The FSM SHALL have three states: PARKED, MOVING, PAUSED.
REQ-019 Launch key 0x2C is edge-qualified: it acts only on a cycle where keycode == 0x2C and the previous-cycle keycode != 0x2C.
REQ-020 PARKED: position held at (X_CENTER, Y_CENTER), motion (0,0); launch edge -> MOVING with motion (+STEP, -STEP).
REQ-021 MOVING: launch edge -> PAUSED; keycode 0x29 -> PARKED with recentre on the next edge.
REQ-022 PAUSED: position and motion frozen; launch edge -> MOVING with the stored motion; 0x29 -> PARKED.
REQ-023 In MOVING, 0x04/0x07/0x16/0x1A SHALL set motion to (-STEP,0)/(+STEP,0)/(0,+STEP)/(0,-STEP); other keycodes leave motion unchanged.
REQ-024 Motion is a signed two's-complement W-bit value; position arithmetic is performed in W+1 bits signed, so no wrap-around.
REQ-025 Each MOVING cycle: m_next = key-selected motion (REQ-023) else current motion; cand = pos + m_next, per axis.
REQ-026 Same-cycle position update SHALL use m_next, not the registered motion.
REQ-027 If cand + SIZE > MAX: pos <= MAX - SIZE; motion on that axis <= -STEP (WALL_MODE 0) or 0 (WALL_MODE 1).
REQ-028 If cand - SIZE < MIN: pos <= MIN + SIZE; motion on that axis <= +STEP (WALL_MODE 0) or 0 (WALL_MODE 1).
REQ-029 Otherwise pos <= cand and motion <= m_next.
REQ-030 X and Y limits are evaluated independently on the same cycle; a corner hit reflects both axes.
REQ-031 Wall limit overrides a same-cycle key: key motion into a wall yields the reflected/zero value.
REQ-032 bounce SHALL be asserted on the cycle after any REQ-027/REQ-028 application; it is low in PARKED and PAUSED.
REQ-033 Reset asserted mid-motion SHALL take priority over all key and wall logic on that edge.

Reset
REQ-034 On Reset: state PARKED, BallX = X_CENTER, BallY = Y_CENTER, motion (0,0), moving = 0, bounce = 0, previous keycode = 0.

Verification
REQ-035 Reset, then keycode 0x2C for 1 cycle -> moving = 1; after 3 more cycles with keycode 0, (BallX, BallY) = (324, 236).
REQ-036 Hold 0x2C for 10 cycles -> exactly one PARKED->MOVING transition, no toggle to PAUSED.
REQ-037 MOVING at X = 634 with motion +1, WALL_MODE 0 -> BallX = 635 with bounce = 1, next cycle BallX = 634.
REQ-038 Same condition with WALL_MODE 1 -> BallX holds 635, X motion 0, Y continues.
REQ-039 MOVING at (4+1, 4+1) with motion (-1,-1) -> corner: both axes reflect, bounce = 1 once.
REQ-040 MOVING, keycode 0x07 and Reset on the same edge -> (320, 240), moving = 0; PAUSE/resume round trip restores the prior motion.
